seg_scan_decoder: RTL and testbench

- Receive-side companion to the 4-digit multiplexed 7-segment driver. Samples the active-low anode (an) and segment (seg) lines and recovers the four displayed digits.
- Checks that each scan frame is well formed, then converts the four BCD digits back to a binary value from 0 to 9999.
- Used as a display loopback/self-test monitor and as a bench-side checker for the death count display.

---
 rtl/seg_scan_decoder.sv | 157 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed, active-low 4-digit 7-segment bus and recovers the
// displayed value as BCD digits and as a binary number (0..9999).
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [13:0] number,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        error
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] SAMPLE_AT  = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT} state_t;

  state_t      state, state_next;
  logic [10:0] sync1, sync2, hist;
  logic [7:0]  stable_cnt;
  logic [1:0]  idx, expect_idx, conv_k;
  logic        idx_ok, seg_ok, sample, bad;
  logic [3:0]  digit, digit_sel;
  logic [3:0]  digits [4];
  logic [13:0] acc, acc_next;
  logic        restart, advance, overwrite, abort, finish;

  // Input synchroniser, one-cycle history and stability counter.
  // NOTE: every register here uses <= so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 11'h7FF;
      sync2      <= 11'h7FF;
      hist       <= 11'h7FF;
      stable_cnt <= '0;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
      hist  <= sync2;
      if (sync2 != hist)                stable_cnt <= '0;
      else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    idx    = 2'd0;
    idx_ok = 1'b1;
    case (hist[10:7])
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx_ok = 1'b0;
    endcase
  end

  always_comb begin
    digit  = 4'd0;
    seg_ok = 1'b1;
    case (hist[6:0])
      7'b1000000: digit = 4'd0;
      7'b1111001: digit = 4'd1;
      7'b0100100: digit = 4'd2;
      7'b0110000: digit = 4'd3;
      7'b0011001: digit = 4'd4;
      7'b0010010: digit = 4'd5;
      7'b0000010: digit = 4'd6;
      7'b1111000: digit = 4'd7;
      7'b0000000: digit = 4'd8;
      7'b0010000: digit = 4'd9;
      default:    seg_ok = 1'b0;
    endcase
  end

  assign sample = idx_ok && (stable_cnt == SAMPLE_AT);

  // Frame events; with expect_idx==1 an index-0 sample is an overwrite.
  always_comb begin
    advance   = (state == CAPTURE) && sample && (idx == expect_idx);
    overwrite = (state == CAPTURE) && sample && (idx == expect_idx - 2'd1);
    restart   = sample && (idx == 2'd0) &&
                ((state == IDLE) || ((state == CAPTURE) && !advance && !overwrite));
    abort     = (state == CAPTURE) && sample && !advance && !overwrite && !restart;
    finish    = (state == CONVERT) && (conv_k == 2'd3);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (restart) state_next = CAPTURE;
      CAPTURE: begin
        if (advance && idx == 2'd3) state_next = CONVERT;
        else if (abort)             state_next = IDLE;
      end
      CONVERT: if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Horner step, most significant digit first: acc*10 + d(3-k).
  assign digit_sel = digits[~conv_k];
  assign acc_next  = {acc[10:0], 3'b000} + {acc[12:0], 1'b0} + {10'd0, digit_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) digits[i] <= '0;
      bad        <= 1'b0;
      expect_idx <= '0;
      acc        <= '0;
      conv_k     <= '0;
      number     <= '0;
      bcd        <= '0;
      valid      <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= abort;
      if (restart) begin
        digits[0]  <= digit;
        bad        <= ~seg_ok;
        expect_idx <= 2'd1;
      end
      if (advance || overwrite) begin
        digits[idx] <= digit;
        if (!seg_ok) bad <= 1'b1;
        if (advance) expect_idx <= expect_idx + 2'd1;
      end
      if (advance && idx == 2'd3) begin
        acc    <= '0;
        conv_k <= '0;
      end
      if (state == CONVERT) begin
        acc    <= acc_next;
        conv_k <= conv_k + 2'd1;
        if (finish) begin
          if (!bad) begin
            number <= acc_next;
            bcd    <= {digits[3], digits[2], digits[1], digits[0]};
            valid  <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan frames on an/seg and checks
// decoded values, pulse counts, exact pulse timing and reset behaviour.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [13:0] number;
  logic [15:0] bcd;
  logic        valid, error;

  int pass_cnt = 0;
  int total_cnt = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int both_cnt = 0;
  int silent_cnt = 0;
  logic [13:0] last_num = '0;
  int v0, e0;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .number(number), .bcd(bcd), .valid(valid), .error(error)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (error) error_cnt++;
    if (valid && error) both_cnt++;
    if (rst_n && (number !== last_num) && !valid) silent_cnt++;
    last_num = number;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;
      4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;
      4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;
      4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;
      4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;
      4'd9: seg_of = 7'b0010000;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int i);
    case (i)
      0: an_of = 4'b1110;
      1: an_of = 4'b1101;
      2: an_of = 4'b1011;
      default: an_of = 4'b0111;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic show(input int i, input logic [6:0] s, input int cycles);
    an  = an_of(i);
    seg = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic blank(input int cycles);
    an  = 4'b1111;
    seg = 7'h7F;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int i = 0; i < 4; i++) show(i, seg_of(v[4*i +: 4]), 64);
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'b1111;
    seg   = 7'h7F;
    repeat (4) @(negedge clk);
    check("reset_number", number, 0);
    check("reset_bcd", bcd, 0);
    check("reset_valid", valid, 0);
    check("reset_error", error, 0);
    rst_n = 1'b1;
    blank(10);

    // 1: frame 1234
    v0 = valid_cnt; e0 = error_cnt;
    send_frame(16'h1234);
    blank(20);
    check("t1_valid_pulses", valid_cnt - v0, 1);
    check("t1_error_pulses", error_cnt - e0, 0);
    check("t1_number", number, 1234);
    check("t1_bcd", bcd, 16'h1234);

    // 3: digit 2 blank -> error exactly 5 cycles after d3 sample
    v0 = valid_cnt; e0 = error_cnt;
    show(0, seg_of(4), 64);
    show(1, seg_of(3), 64);
    show(2, 7'h7F, 64);
    an  = an_of(3);
    seg = seg_of(1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3_error_before", error, 0);
    @(negedge clk);
    check("t3_error_at_t5", error, 1);
    check("t3_valid_at_t5", valid, 0);
    @(negedge clk);
    check("t3_error_one_cycle", error, 0);
    repeat (50) @(negedge clk);
    blank(20);
    check("t3_valid_pulses", valid_cnt - v0, 0);
    check("t3_error_pulses", error_cnt - e0, 1);
    check("t3_number_held", number, 1234);
    check("t3_bcd_held", bcd, 16'h1234);

    // 2: back-to-back 9999 then 0000
    v0 = valid_cnt; e0 = error_cnt;
    send_frame(16'h9999);
    check("t2_number_9999", number, 9999);
    check("t2_bcd_9999", bcd, 16'h9999);
    send_frame(16'h0000);
    blank(20);
    check("t2_valid_pulses", valid_cnt - v0, 2);
    check("t2_number_0", number, 0);
    check("t2_bcd_0", bcd, 16'h0000);
    check("t2_error_pulses", error_cnt - e0, 0);

    // 4: start mid-scan, 2-cycle glitch inside idx1 window; expect 0567
    v0 = valid_cnt; e0 = error_cnt;
    show(2, seg_of(5), 64);
    show(3, seg_of(0), 64);
    check("t4_ignored_valid", valid_cnt - v0, 0);
    check("t4_ignored_error", error_cnt - e0, 0);
    show(0, seg_of(7), 64);
    show(1, seg_of(6), 20);
    show(1, 7'b0000000, 2);
    show(1, seg_of(6), 42);
    show(2, seg_of(5), 64);
    show(3, seg_of(0), 64);
    blank(20);
    check("t4_valid_pulses", valid_cnt - v0, 1);
    check("t4_error_pulses", error_cnt - e0, 0);
    check("t4_number", number, 567);
    check("t4_bcd", bcd, 16'h0567);

    // 5: idx0 then idx2 -> error, then good frame 0042
    v0 = valid_cnt; e0 = error_cnt;
    show(0, seg_of(2), 64);
    show(2, seg_of(0), 64);
    blank(20);
    check("t5_error_pulses", error_cnt - e0, 1);
    check("t5_valid_pulses", valid_cnt - v0, 0);
    check("t5_number_held", number, 0567);
    send_frame(16'h0042);
    blank(20);
    check("t5_valid_after", valid_cnt - v0, 1);
    check("t5_number", number, 42);
    check("t5_bcd", bcd, 16'h0042);

    // 6: reset during 2nd CONVERT cycle, then a normal frame
    show(0, seg_of(1), 64);
    show(1, seg_of(8), 64);
    show(2, seg_of(0), 64);
    an  = an_of(3);
    seg = seg_of(9);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_number_cleared", number, 0);
    check("t6_bcd_cleared", bcd, 0);
    v0 = valid_cnt; e0 = error_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    blank(20);
    check("t6_no_valid", valid_cnt - v0, 0);
    check("t6_no_error", error_cnt - e0, 0);
    check("t6_number_still0", number, 0);
    send_frame(16'h9081);
    blank(20);
    check("t6_valid_after", valid_cnt - v0, 1);
    check("t6_number", number, 9081);
    check("t6_bcd", bcd, 16'h9081);

    check("never_valid_and_error", both_cnt, 0);
    check("no_silent_number_change", silent_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
